// File: rtl/comparator_search.sv
// comparator_search: binary-search initiator that recovers the comparator's a operand by probing b.
// Optional macro COMPARATOR_SEARCH_CHECK_EN adds the err port flagging contradictory g=l=1 verdicts.
module comparator_search #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             g,
   input  logic             l,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [WIDTH-1:0] result
`ifdef COMPARATOR_SEARCH_CHECK_EN
   ,
   output logic             err
`endif
);
   localparam logic [WIDTH-1:0] MAXP  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] FIRST = MAXP >> 1;
   localparam logic [WIDTH:0]   TOP   = {1'b0, MAXP};
   typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
   state_t state;
   logic [WIDTH:0] lo, hi, nlo, nhi;
   logic [WIDTH-1:0] nmid;
   logic at_edge, empty, bad;
   // Narrow the window from the current verdict; g wins over l when both are high
   always_comb begin
      nlo     = g ? {1'b0, probe} + 1'b1 : lo;
      nhi     = (!g && l) ? {1'b0, probe} - 1'b1 : hi;
      nmid    = WIDTH'((nlo + nhi) >> 1);
      at_edge = g ? (probe == MAXP) : (probe == '0);
      empty   = nlo > nhi;
`ifdef COMPARATOR_SEARCH_CHECK_EN
      bad     = g & l;
`else
      bad     = 1'b0;
`endif
   end
   // Search FSM with registered outputs; reset aborts any search without a done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         lo     <= '0;
         hi     <= TOP;
         probe  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         found  <= 1'b0;
         result <= '0;
`ifdef COMPARATOR_SEARCH_CHECK_EN
         err    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  lo    <= '0;
                  hi    <= TOP;
                  probe <= FIRST;
                  found <= 1'b0;
                  busy  <= 1'b1;
`ifdef COMPARATOR_SEARCH_CHECK_EN
                  err   <= 1'b0;
`endif
                  state <= PROBE;
               end
            end
            PROBE: begin
               if (bad) begin
`ifdef COMPARATOR_SEARCH_CHECK_EN
                  err    <= 1'b1;
`endif
                  found  <= 1'b0;
                  result <= probe;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else if (!g && !l) begin
                  result <= probe;
                  found  <= 1'b1;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else if (at_edge || empty) begin
                  found  <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  lo     <= nlo;
                  hi     <= nhi;
                  probe  <= nmid;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
